// File: rtl/pkt_pkg.sv
// pkt_pkg: shared defaults and FSM state encoding for packet_stream_reader.
//   PKT_ADDR_W / PKT_DATA_W / PKT_LEN_W : default widths (1024-entry byte buffer,
//                                         packet length 0..1024)
//   pkt_state_t                          : controller state encoding
package pkt_pkg;
  localparam int PKT_ADDR_W = 10;
  localparam int PKT_DATA_W = 8;
  localparam int PKT_LEN_W  = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHK_H = 3'd2,
    ST_CHK_L = 3'd3,
    ST_DONE  = 3'd4
  } pkt_state_t;
endpackage

// File: rtl/pkt_skid_buf.sv
// pkt_skid_buf: 2-entry fall-through skid buffer between the buffer read port
// and the output stream. When empty, an incoming byte is presented directly so
// the first byte appears the same cycle its read data returns; otherwise bytes
// queue and are presented from the head entry, held stable until accepted.
//   i_clk, i_rst           : clock, async active-high reset
//   i_in_valid/data/last   : byte entering the stream (caller guarantees room)
//   o_out_valid/data/last  : stream head
//   i_out_ready            : downstream accepts head
//   o_count                : stored entries (0..2), excludes the bypass byte
module pkt_skid_buf
  import pkt_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  input  logic              i_out_ready,
  output logic [1:0]        o_count
);
  // entries are {last, data}
  logic [DATA_W:0] r_e0, r_e1;
  logic [1:0]      r_count;
  logic [DATA_W:0] w_in, w_out;

  assign w_in  = {i_in_last, i_in_data};
  // head is the incoming byte only when nothing is stored ahead of it
  assign w_out = ((r_count != 2'd0) || !i_in_valid) ? r_e0 : w_in;

  assign o_out_valid = (r_count != 2'd0) || i_in_valid;
  assign o_out_data  = w_out[DATA_W-1:0];
  assign o_out_last  = w_out[DATA_W];
  assign o_count     = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_in_valid && !i_out_ready) begin
            r_e0    <= w_in;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (i_out_ready) begin
            if (i_in_valid) r_e0 <= w_in;
            else            r_count <= 2'd0;
          end else if (i_in_valid) begin
            r_e1    <= w_in;
            r_count <= 2'd2;
          end
        end
        default: begin
          if (i_out_ready) begin
            r_e0 <= r_e1;
            if (i_in_valid) r_e1 <= w_in;
            else            r_count <= 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/packet_stream_reader.sv
// packet_stream_reader: streams a packet of i_len bytes starting at
// i_base_addr out of a synchronous packet buffer onto a valid/ready stream.
// Optional macro PKT_CHKSUM_EN appends a 16-bit byte sum (high, then low).
//   i_clk, i_rst                : clock, async active-high reset
//   i_start, i_base_addr, i_len : packet request (accepted only when idle)
//   o_rd_addr, o_rd_en, i_rd_data : buffer read port, 1-cycle read latency
//   o_tx_data/valid/last, i_tx_ready : output byte stream
//   o_busy, o_done              : status; o_done pulses after the final byte
module packet_stream_reader
  import pkt_pkg::*;
#(
  parameter int ADDR_W = PKT_ADDR_W,
  parameter int DATA_W = PKT_DATA_W,
  parameter int LEN_W  = PKT_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_tx_last,
  output logic              o_busy,
  output logic              o_done
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  pkt_state_t        r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_rd_left;
  logic              r_pend;   // read data is on i_rd_data this cycle
  logic              r_busy, r_done;

  logic              w_in_valid, w_in_last;
  logic [DATA_W-1:0] w_in_data;
  logic              w_out_valid, w_out_last;
  logic [DATA_W-1:0] w_out_data;
  logic [1:0]        w_count;
  logic              w_pop, w_room, w_issue, w_reads_done;
  logic [2:0]        w_occ;
  logic [LEN_W-1:0]  w_len_sat;

  assign w_pop = w_out_valid && i_tx_ready;

  // Stored bytes plus the read returning now must leave a slot for a new read.
  // A pop this cycle frees one, which is what lets 2 entries cover the 2-cycle
  // read loop at 1 byte/cycle; hence o_rd_en is combinational.
  assign w_occ        = 3'(w_count) + 3'(r_pend);
  assign w_room       = w_occ < (3'd2 + 3'(w_pop));
  assign w_issue      = (r_state == ST_READ) && (r_rd_left != '0) && w_room;
  assign w_reads_done = (r_rd_left == '0) && !r_pend;
  assign w_len_sat    = (i_len > MAX_LEN) ? MAX_LEN : i_len;

`ifdef PKT_CHKSUM_EN
  logic [15:0] r_sum;
  logic        r_chk_sent;
  logic        w_chk_push;

  // checksum bytes never coincide with returning read data: CHK states are
  // entered only once all reads have landed
  assign w_chk_push = ((r_state == ST_CHK_H) || ((r_state == ST_CHK_L) && !r_chk_sent))
                      && (w_count != 2'd2);
  assign w_in_valid = r_pend || w_chk_push;
  assign w_in_data  = r_pend ? i_rd_data :
                      (r_state == ST_CHK_H) ? DATA_W'(r_sum[15:8]) : DATA_W'(r_sum[7:0]);
  assign w_in_last  = !r_pend && (r_state == ST_CHK_L);
`else
  logic r_pend_last;
  assign w_in_valid = r_pend;
  assign w_in_data  = i_rd_data;
  assign w_in_last  = r_pend_last;
`endif

  pkt_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (w_in_valid),
    .i_in_data   (w_in_data),
    .i_in_last   (w_in_last),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data),
    .o_out_last  (w_out_last),
    .i_out_ready (i_tx_ready),
    .o_count     (w_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_rd_left <= '0;
      r_pend    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef PKT_CHKSUM_EN
      r_sum      <= '0;
      r_chk_sent <= 1'b0;
`else
      r_pend_last <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_pend <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        r_rd_left <= r_rd_left - LEN_W'(1);
      end
`ifdef PKT_CHKSUM_EN
      if (r_pend) r_sum <= r_sum + 16'(i_rd_data);
`else
      r_pend_last <= w_issue && (r_rd_left == LEN_W'(1));
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_READ;
            r_rd_addr <= i_base_addr;
            r_rd_left <= w_len_sat;
            r_busy    <= 1'b1;
`ifdef PKT_CHKSUM_EN
            r_sum      <= '0;
            r_chk_sent <= 1'b0;
`endif
          end
        end
        ST_READ: begin
`ifdef PKT_CHKSUM_EN
          // the byte returning now is summed on this edge
          if (r_rd_left == '0) r_state <= ST_CHK_H;
`else
          // second term only fires for an empty packet
          if ((w_pop && w_out_last) || (w_reads_done && (w_count == 2'd0))) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
`endif
        end
`ifdef PKT_CHKSUM_EN
        ST_CHK_H: begin
          if (w_chk_push) r_state <= ST_CHK_L;
        end
        ST_CHK_L: begin
          if (w_chk_push) r_chk_sent <= 1'b1;
          if (w_pop && w_out_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_addr  = r_rd_addr;
  assign o_rd_en    = w_issue;
  assign o_tx_data  = w_out_data;
  assign o_tx_valid = w_out_valid;
  assign o_tx_last  = w_out_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
endmodule
